// File: rtl/serializer_pkg.sv
// Shared constants for the PISO serializer: FSM state encodings and default frame width.
package serializer_pkg;

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_SHIFT = 1'b1;

  localparam int unsigned DEFAULT_WIDTH = 4;

endpackage

// File: rtl/ser_bit_counter.sv
// Bit-position counter for the serializer: clears to zero, counts up to WIDTH-1 and stops there.
module ser_bit_counter #(
  parameter int unsigned WIDTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       clear,
  input  logic                       inc,
  output logic [$clog2(WIDTH)-1:0]   count,
  output logic                       tc
);

  localparam int unsigned CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  logic [CW-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      cnt_q <= '0;
    end else if (inc && !tc) begin
      cnt_q <= cnt_q + CW'(1);
    end
  end

  assign count = cnt_q;
  assign tc    = (cnt_q == LAST);

endmodule

// File: rtl/piso_serializer.sv
// Parallel-in serial-out serializer: LSB-first frames of WIDTH bits with a valid/ready load
// handshake and gapless back-to-back frames.
module piso_serializer
  import serializer_pkg::*;
#(
  parameter int unsigned WIDTH    = DEFAULT_WIDTH,
  parameter logic        IDLE_BIT = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_valid,
  input  logic [WIDTH-1:0] load_data,
  output logic             load_ready,
  output logic             ser_out,
  output logic             ser_valid,
  output logic             bit_last,
  output logic             busy
);

  localparam int unsigned CW = $clog2(WIDTH);
  localparam logic [CW-1:0] PRE_LAST = CW'(WIDTH - 2);

  logic [0:0]       state_q, state_d;
  logic [WIDTH-1:0] sreg_q, sreg_d;
  logic             ser_out_q, ser_out_d;
  logic             ser_valid_q, ser_valid_d;
  logic             bit_last_q, bit_last_d;

  logic [CW-1:0] cnt;
  logic          cnt_tc;
  logic          in_shift;
  logic          last_bit;
  logic          handshake;

  assign in_shift   = (state_q == ST_SHIFT);
  assign last_bit   = in_shift && cnt_tc;
  assign load_ready = !rst && (!in_shift || cnt_tc);
  assign handshake  = load_valid && load_ready;

  ser_bit_counter #(
    .WIDTH (WIDTH)
  ) u_bit_counter (
    .clk   (clk),
    .rst   (rst),
    .clear (handshake || last_bit),
    .inc   (in_shift),
    .count (cnt),
    .tc    (cnt_tc)
  );

  // sreg_q[0] is always the bit currently on ser_out while a frame is active
  always_comb begin
    state_d     = state_q;
    sreg_d      = sreg_q;
    ser_out_d   = IDLE_BIT;
    ser_valid_d = 1'b0;
    bit_last_d  = 1'b0;
    if (handshake) begin
      state_d     = ST_SHIFT;
      sreg_d      = load_data;
      ser_out_d   = load_data[0];
      ser_valid_d = 1'b1;
    end else if (last_bit) begin
      state_d = ST_IDLE;
    end else if (in_shift) begin
      sreg_d      = sreg_q >> 1;
      ser_out_d   = sreg_q[1];
      ser_valid_d = 1'b1;
      bit_last_d  = (cnt == PRE_LAST);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      sreg_q      <= '0;
      ser_out_q   <= IDLE_BIT;
      ser_valid_q <= 1'b0;
      bit_last_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      sreg_q      <= sreg_d;
      ser_out_q   <= ser_out_d;
      ser_valid_q <= ser_valid_d;
      bit_last_q  <= bit_last_d;
    end
  end

  assign ser_out   = ser_out_q;
  assign ser_valid = ser_valid_q;
  assign bit_last  = bit_last_q;
  assign busy      = ser_valid_q;

endmodule
